ntr_cmd_capture: RTL

NTR_CMD_CAPTURE -- requirements
Module: ntr_cmd_capture

---
 rtl/ntr_cmd_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ntr_cmd_capture.sv
// Cartridge-bus command capture.
// Synchronizes the asynchronous cartridge bus (clock, chip select, data) into
// the clk domain, assembles CMD_BYTES bytes per command (first byte ends up in
// the MSBs) and presents each completed command on a valid/ready handshake.
// A partial command cut short by chip select deasserting raises a one-cycle
// abort pulse. A completed command that cannot be presented because the
// previous one is still waiting sets a sticky overrun flag.
module ntr_cmd_capture #(
   parameter int CMD_BYTES   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ntr_clk,
   input  logic                               ntr_cs1,
   input  logic [7:0]                         ntr_data,
   output logic [8*CMD_BYTES-1:0]             cmd,
   output logic                               cmd_valid,
   input  logic                               cmd_ready,
   output logic [$clog2(CMD_BYTES+1)-1:0]     byte_count,
   output logic                               abort,
   output logic                               overrun
);

   localparam int W  = 8 * CMD_BYTES;
   localparam int CW = $clog2(CMD_BYTES + 1);
   // Fewer than two stages would not be a synchronizer at all.
   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   // Synchronizer chains: index 0 is the first flop, index SS-1 is the output.
   logic [SS-1:0]      clk_sync_q;
   logic [SS-1:0]      cs_sync_q;
   logic [SS-1:0][7:0] data_sync_q;

   logic               clk_s;
   logic               cs_s;
   logic [7:0]         data_s;

   // Edge detectors on the synchronized bus clock and chip select.
   logic               clk_d_q;
   logic               cs_d_q;

   // Capture state.
   logic [W-1:0]       shift_q,   shift_d;
   logic [CW-1:0]      cnt_q,     cnt_d;
   logic [W-1:0]       cmd_q,     cmd_d;
   logic               valid_q,   valid_d;
   logic               abort_q,   abort_d;
   logic               overrun_q, overrun_d;

   // Decoded events.
   logic               bus_edge;
   logic               cs_rise;
   logic               last_byte;
   logic               cmd_done;
   logic [W-1:0]       shift_nxt;

   // Bring the asynchronous bus signals into the clk domain; clock and chip
   // select reset high so that releasing reset never looks like a bus edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '1;
         cs_sync_q   <= '1;
         data_sync_q <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SS-2:0], ntr_clk};
         cs_sync_q   <= {cs_sync_q[SS-2:0], ntr_cs1};
         data_sync_q <= {data_sync_q[SS-2:0], ntr_data};
      end
   end

   assign clk_s  = clk_sync_q[SS-1];
   assign cs_s   = cs_sync_q[SS-1];
   assign data_s = data_sync_q[SS-1];

   // Delayed copies of the synchronized clock and chip select for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_d_q <= 1'b1;
         cs_d_q  <= 1'b1;
      end else begin
         clk_d_q <= clk_s;
         cs_d_q  <= cs_s;
      end
   end

   // Event decode: a bus byte is taken on a synchronized rising ntr_clk while
   // selected; chip-select rising edge ends the current transfer.
   always_comb begin
      bus_edge  = clk_s & ~clk_d_q & ~cs_s;
      cs_rise   = cs_s & ~cs_d_q;
      last_byte = (cnt_q == CW'(CMD_BYTES - 1));
      cmd_done  = bus_edge & last_byte;
      shift_nxt = (shift_q << 8) | W'(data_s);
   end

   // Next-state logic for byte assembly, command hand-off, abort and overrun.
   // The completing byte is merged into the command word directly from
   // shift_nxt so that cmd reflects it in the same cycle cmd_valid rises.
   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      valid_d   = valid_q;
      abort_d   = 1'b0;
      overrun_d = overrun_q;

      if (bus_edge) begin
         shift_d = shift_nxt;
         cnt_d   = last_byte ? '0 : cnt_q + CW'(1);
      end else if (cs_rise && (cnt_q != '0)) begin
         cnt_d   = '0;
         abort_d = 1'b1;
      end

      if (cmd_done) begin
         if (!valid_q || cmd_ready) begin
            // Either nothing is pending or the pending command leaves this
            // cycle, so the new one takes its place without a gap.
            cmd_d   = shift_nxt;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && cmd_ready) begin
         valid_d = 1'b0;
      end
   end

   // Capture state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q   <= '0;
         cnt_q     <= '0;
         cmd_q     <= '0;
         valid_q   <= 1'b0;
         abort_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         valid_q   <= valid_d;
         abort_q   <= abort_d;
         overrun_q <= overrun_d;
      end
   end

   assign cmd        = cmd_q;
   assign cmd_valid  = valid_q;
   assign byte_count = cnt_q;
   assign abort      = abort_q;
   assign overrun    = overrun_q;

endmodule
